tdm_demux: RTL
==============

Name: tdm_demux

Overview:
- Receive end of the two-channel time-division link whose transmit end is the 2:1 select mux.
- Takes one interleaved word stream with a frame marker and splits it back into channel A and channel B.
- Each frame is two slots: slot A, which carries frame_sync, then slot B.
- Tracks frame alignment with a lock state machine and reports framing loss; sits between the link input and the per-channel consumers.

Parameters:
WIDTH, 8, data word width in bits
SYNC_TIMEOUT, 16, consecutive idle cycles while locked before lock is dropped (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  WIDTH  interleaved data word
din_valid  input  1  din valid this cycle
frame_sync  input  1  marks din as slot A (frame start); ignored when din_valid=0
din_par  input  1  parity bit for din; used only with DEMUX_PARITY_EN
a_out  output  WIDTH  channel A word, held until next A word
a_valid  output  1  one-cycle pulse, a_out updated
b_out  output  WIDTH  channel B word, held until next B word
b_valid  output  1  one-cycle pulse, b_out updated
locked  output  1  frame alignment held
frame_err  output  1  one-cycle pulse on framing violation
par_err  output  1  one-cycle pulse on parity mismatch

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: a_out=0, b_out=0, a_valid=0, b_valid=0, locked=0, frame_err=0, par_err=0, state=HUNT, slot=A, idle count=0.
- Reset mid-frame discards any partial frame.
- All outputs are registered. Latency from an accepted word to its out/valid is 1 cycle.
- The *_valid, frame_err and par_err signals are single-cycle pulses.
- A cycle with din_valid=0 is idle. No routing happens and frame_sync is ignored.
- State HUNT (locked=0):
  - din_valid=1 with frame_sync=1: route din to a_out, pulse a_valid, set slot=B, go to SYNC, locked=1.
  - din_valid=1 with frame_sync=0: drop the word. No pulses.
- State SYNC (locked=1):
  - slot=A with frame_sync=1: route to A, set slot=B.
  - slot=B with frame_sync=0: route to B, set slot=A.
  - slot=B with frame_sync=1 (early frame start): pulse frame_err, route the word to A, set slot=B, stay in SYNC.
  - slot=A with frame_sync=0 (missing marker): pulse frame_err, drop the word, go to HUNT, locked=0, slot=A.
- Idle counter, SYNC only:
  - Increments each idle cycle and clears on any valid word.
  - On the edge that completes SYNC_TIMEOUT consecutive idle cycles: go to HUNT, locked=0, slot=A, counter cleared.
  - The counter is held at 0 in HUNT.
- Counter width is clog2(SYNC_TIMEOUT+1). It saturates; it never wraps.
- a_valid and b_valid are never high in the same cycle.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - A valid word passes parity when din_par equals the XOR of all din bits.
  - On mismatch, the word is dropped and par_err pulses.
  - In SYNC, the slot still advances exactly as if the word had been routed, and no frame_err is raised for that word.
  - In HUNT, a mismatched sync word leaves the block in HUNT.
  - Mismatch clears the idle counter like any valid word.
- Not defined: din_par is ignored, par_err is tied to 0, and all words are checked only by the framing rules.

Test Plan:
1. Release rst; send 0x11 (sync), then 0x22 (no sync) on consecutive cycles -> a_out=0x11 with a_valid one cycle after 0x11; b_out=0x22 with b_valid one cycle later; locked=1 from the first edge.
2. After reset, send 0x55 and 0x66 without sync -> no valid pulses; locked=0; a_out=b_out=0.
3. When locked, send 0x10 (sync) then 0x20 (sync), then 0x30 (no sync) -> frame_err pulses on 0x20; a_out=0x20; b_out=0x30; locked stays 1.
4. When locked with slot=A, send 0x44 without sync -> frame_err pulses, no a_valid, locked=0; next sync word 0x45 -> a_out=0x45, locked=1.
5. Set SYNC_TIMEOUT=4. When locked, hold 3 idle cycles then send a B word -> locked stays 1. Then hold 4 idle cycles -> locked=0 after the 4th.
6. With DEMUX_PARITY_EN, when locked at slot A, send 0x03 sync with din_par=1 -> par_err pulses, no a_valid; next word 0x07 no sync, din_par=1 -> b_out=0x07. Without the macro, the same stimulus -> a_out=0x03, par_err stays 0.

Source files
------------

// File: rtl/tdm_demux.sv
// Two-channel TDM receive demux: splits an interleaved A/B word stream using frame_sync, with a lock FSM.
// Optional build macro DEMUX_PARITY_EN adds per-word parity checking on din_par.
module tdm_demux #(
  parameter int WIDTH        = 8,
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  input  logic             din_par,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             locked,
  output logic             frame_err,
  output logic             par_err
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SYNC_TIMEOUT - 1);

  localparam logic [0:0] S_HUNT = 1'b0;
  localparam logic [0:0] S_SYNC = 1'b1;
  localparam logic [0:0] SLOT_A = 1'b0;
  localparam logic [0:0] SLOT_B = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       r_slot;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_out;
  logic [WIDTH-1:0] r_b_out;
  logic             r_a_valid;
  logic             r_b_valid;
  logic             r_frame_err;
  logic             r_par_err;

  logic [0:0]    w_state_next;
  logic [0:0]    w_slot_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_route_a;
  logic          w_route_b;
  logic          w_frame_err;
  logic          w_par_err;
  logic          w_par_ok;

`ifdef DEMUX_PARITY_EN
  assign w_par_ok = (din_par == ^din);
`else
  logic w_unused_par;
  assign w_unused_par = din_par;
  assign w_par_ok     = 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    w_cnt_next   = r_cnt;
    w_route_a    = 1'b0;
    w_route_b    = 1'b0;
    w_frame_err  = 1'b0;
    w_par_err    = 1'b0;
    if (!din_valid) begin
      // The counter only runs while locked; reaching the last idle cycle drops lock.
      if (r_state == S_SYNC) begin
        if (r_cnt >= C_LAST) begin
          w_state_next = S_HUNT;
          w_slot_next  = SLOT_A;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end else begin
        w_cnt_next = '0;
      end
    end else begin
      w_cnt_next = '0;
      if (!w_par_ok) begin
        // Bad word is dropped, but the slot keeps pace so the next word lands correctly.
        w_par_err = 1'b1;
        if (r_state == S_SYNC)
          w_slot_next = (frame_sync || r_slot == SLOT_A) ? SLOT_B : SLOT_A;
      end else if (r_state == S_HUNT) begin
        if (frame_sync) begin
          w_route_a    = 1'b1;
          w_slot_next  = SLOT_B;
          w_state_next = S_SYNC;
        end
      end else begin
        case ({r_slot, frame_sync})
          {SLOT_A, 1'b1}: begin
            w_route_a   = 1'b1;
            w_slot_next = SLOT_B;
          end
          {SLOT_B, 1'b0}: begin
            w_route_b   = 1'b1;
            w_slot_next = SLOT_A;
          end
          {SLOT_B, 1'b1}: begin
            w_frame_err = 1'b1;
            w_route_a   = 1'b1;
            w_slot_next = SLOT_B;
          end
          default: begin
            w_frame_err  = 1'b1;
            w_state_next = S_HUNT;
            w_slot_next  = SLOT_A;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_slot      <= SLOT_A;
      r_cnt       <= '0;
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_slot      <= w_slot_next;
      r_cnt       <= w_cnt_next;
      r_a_valid   <= w_route_a;
      r_b_valid   <= w_route_b;
      r_frame_err <= w_frame_err;
      r_par_err   <= w_par_err;
      if (w_route_a) r_a_out <= din;
      if (w_route_b) r_b_out <= din;
    end
  end

  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign a_valid   = r_a_valid;
  assign b_valid   = r_b_valid;
  assign locked    = (r_state == S_SYNC);
  assign frame_err = r_frame_err;
  assign par_err   = r_par_err;

endmodule
